// File: rtl/tick_timer_sched.sv
// Multi-channel countdown scheduler sharing the 1 s tick among NUM_CH timers.
// Expiries are merged per channel and serialised by a round-robin arbiter.
module tick_timer_sched #(
    parameter int  NUM_CH   = 4,
    parameter int  PERIOD_W = 8,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_in,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_cmd,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic [NUM_CH-1:0]   active,
    output logic [NUM_CH-1:0]   expire,
    output logic [NUM_CH-1:0]   ovf,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CH_W-1:0]     evt_ch
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid, once raised, holds its payload until that edge.
    logic                              r_cfg_ready;
    logic [NUM_CH-1:0]                 r_state;
    logic [NUM_CH-1:0]                 r_periodic;
    logic [NUM_CH-1:0][PERIOD_W-1:0]   r_count;
    logic [NUM_CH-1:0][PERIOD_W-1:0]   r_period;
    logic [NUM_CH-1:0]                 r_expire;
    logic [NUM_CH-1:0]                 r_pending;
    logic [NUM_CH-1:0]                 r_ovf;
    logic                              r_evt_valid;
    logic [CH_W-1:0]                   r_evt_ch;
    logic [CH_W-1:0]                   r_ptr;

    logic                              w_cfg_fire;
    logic                              w_cfg_start;
    logic                              w_evt_fire;
    logic [NUM_CH-1:0]                 w_consume;
    logic [NUM_CH-1:0]                 w_cmd_clr;
    logic [NUM_CH-1:0]                 w_pend_next;
    logic [NUM_CH-1:0]                 w_ovf_set;
    logic [CH_W-1:0]                   w_ptr;
    logic [CH_W-1:0]                   w_idx;
    logic [CH_W-1:0]                   w_pick;
    logic                              w_found;

    assign w_cfg_fire  = cfg_valid & r_cfg_ready;
    assign w_cfg_start = (cfg_cmd == 2'b01 || cfg_cmd == 2'b10) && (cfg_period != '0);
    assign w_evt_fire  = r_evt_valid & evt_ready;

    always_comb begin
        w_consume = '0;
        w_cmd_clr = '0;
        if (w_evt_fire) w_consume[r_evt_ch] = 1'b1;
        if (w_cfg_fire) w_cmd_clr[cfg_ch] = 1'b1;
    end

    // A channel consumed and re-expiring in the same clk keeps its pending bit without overflow.
    assign w_pend_next = (r_pending & ~w_consume) | r_expire;
    assign w_ovf_set   = r_expire & r_pending & ~w_consume;
    assign w_ptr       = !w_evt_fire ? r_ptr :
                         (r_evt_ch == CH_W'(NUM_CH - 1)) ? '0 : r_evt_ch + CH_W'(1);

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = CH_W'((int'(w_ptr) + k) % NUM_CH);
            if (!w_found && w_pend_next[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Per-channel IDLE/RUN FSM; an accepted command masks the tick for its own channel only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_ready <= 1'b0;
            r_state     <= '0;
            r_periodic  <= '0;
            r_count     <= '0;
            r_period    <= '0;
            r_expire    <= '0;
        end else begin
            r_cfg_ready <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                r_expire[c] <= 1'b0;
                if (w_cfg_fire && cfg_ch == CH_W'(c)) begin
                    if (w_cfg_start) begin
                        r_state[c]    <= ST_RUN;
                        r_count[c]    <= cfg_period;
                        r_period[c]   <= cfg_period;
                        r_periodic[c] <= cfg_cmd[1];
                    end else begin
                        r_state[c] <= ST_IDLE;
                        r_count[c] <= '0;
                    end
                end else if (tick_in && r_state[c] == ST_RUN) begin
                    if (r_count[c] == PERIOD_W'(1)) begin
                        r_expire[c] <= 1'b1;
                        if (r_periodic[c]) begin
                            r_count[c] <= r_period[c];
                        end else begin
                            r_state[c] <= ST_IDLE;
                            r_count[c] <= '0;
                        end
                    end else begin
                        r_count[c] <= r_count[c] - PERIOD_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending   <= '0;
            r_ovf       <= '0;
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_ptr       <= '0;
        end else begin
            r_pending <= w_pend_next;
            r_ovf     <= (r_ovf | w_ovf_set) & ~w_cmd_clr;
            r_ptr     <= w_ptr;
            if (!r_evt_valid || w_evt_fire) begin
                r_evt_valid <= w_found;
                r_evt_ch    <= w_pick;
            end
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign active    = r_state;
    assign expire    = r_expire;
    assign ovf       = r_ovf;
    assign evt_valid = r_evt_valid;
    assign evt_ch    = r_evt_ch;

endmodule

// File: tb/tb_tick_timer_sched.sv
// Directed bench for tick_timer_sched: expected event channels are queued as
// stimulus is issued and a negedge monitor checks every delivered event.
module tb_tick_timer_sched;
    localparam int NUM_CH   = 4;
    localparam int PERIOD_W = 8;
    localparam int CH_W     = 2;

    logic                clk;
    logic                rst;
    logic                tick_in;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch;
    logic [1:0]          cfg_cmd;
    logic [PERIOD_W-1:0] cfg_period;
    logic [NUM_CH-1:0]   active;
    logic [NUM_CH-1:0]   expire;
    logic [NUM_CH-1:0]   ovf;
    logic                evt_valid;
    logic                evt_ready;
    logic [CH_W-1:0]     evt_ch;

    logic [CH_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_exp1   = 0;

    tick_timer_sched #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_cmd(cfg_cmd), .cfg_period(cfg_period),
        .active(active), .expire(expire), .ovf(ovf),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drivers: all inputs change 2 time units after a rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_tick();
        tick_in = 1'b1;
        idle(1);
        tick_in = 1'b0;
    endtask

    task automatic do_cfg(input logic [CH_W-1:0] ch, input logic [1:0] cmd,
                          input logic [PERIOD_W-1:0] per, input logic with_tick);
        int waited = 0;
        while (!cfg_ready && waited < 20) begin
            idle(1);
            waited++;
        end
        if (!cfg_ready) check("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_cmd    = cmd;
        cfg_period = per;
        tick_in    = with_tick;
        idle(1);
        cfg_valid = 1'b0;
        tick_in   = 1'b0;
    endtask

    // scoreboard monitor: a handshake completes on the edge after this sample
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL evt_unexpected: got ch %0d expected no event", evt_ch);
            end else begin
                logic [CH_W-1:0] e;
                e = exp_q.pop_front();
                if (evt_ch !== e) begin
                    n_errors++;
                    $display("FAIL evt_order: got ch %0d expected ch %0d", evt_ch, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; tick_in = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_cmd = '0; cfg_period = '0; evt_ready = 1'b0;
        #3 rst = 1'b1;
        idle(3);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_ovf_expire", 32'({ovf, expire, evt_ch}), 32'd0);
        rst = 1'b0;
        check("cfg_ready_still_low", 32'(cfg_ready), 32'd0);
        idle(1);
        check("cfg_ready_rise", 32'(cfg_ready), 32'd1);

        // ch0 one-shot period 3
        do_cfg(2'd0, 2'b01, 8'd3, 1'b0);
        check("t1_active", 32'(active), 32'b0001);
        do_tick();
        check("t1_tick1_expire", 32'(expire), 32'd0);
        do_tick();
        check("t1_tick2_expire", 32'(expire), 32'd0);
        do_tick();
        exp_q.push_back(2'd0);
        check("t1_tick3_expire", 32'(expire), 32'b0001);
        check("t1_active_off", 32'(active), 32'd0);
        check("t1_evt_not_yet", 32'(evt_valid), 32'd0);
        idle(1);
        check("t1_evt_valid", 32'(evt_valid), 32'd1);
        check("t1_evt_ch", 32'(evt_ch), 32'd0);
        check("t1_expire_pulse", 32'(expire), 32'd0);
        evt_ready = 1'b1;
        idle(1);
        check("t1_evt_done", 32'(evt_valid), 32'd0);

        // pointer now 1: ch0 and ch2 expire together -> 2 then 0
        do_cfg(2'd0, 2'b01, 8'd1, 1'b0);
        do_cfg(2'd2, 2'b01, 8'd1, 1'b0);
        do_tick();
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd0);
        check("t3b_expire_both", 32'(expire), 32'b0101);
        idle(1);
        check("t3b_first", 32'({evt_valid, evt_ch}), 32'b110);
        idle(1);
        check("t3b_second", 32'({evt_valid, evt_ch}), 32'b100);
        idle(1);
        check("t3b_empty", 32'(evt_valid), 32'd0);

        // ch1 periodic period 2 over 6 ticks
        do_cfg(2'd1, 2'b10, 8'd2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_tick();
            if (expire[1]) n_exp1++;
            check("t2_expire_pattern", 32'(expire), (i % 2 == 1) ? 32'b0010 : 32'd0);
            if (i % 2 == 1) exp_q.push_back(2'd1);
        end
        check("t2_expire_count", 32'(n_exp1), 32'd3);
        check("t2_active", 32'(active), 32'b0010);
        idle(3);
        check("t2_no_ovf", 32'(ovf), 32'd0);
        do_cfg(2'd1, 2'b00, 8'd0, 1'b0);
        check("t2_stopped", 32'(active), 32'd0);

        // overflow on ch3 with consumer stalled
        evt_ready = 1'b0;
        do_cfg(2'd3, 2'b10, 8'd1, 1'b0);
        do_tick();
        exp_q.push_back(2'd3);
        idle(1);
        check("ovf_evt_first", 32'({evt_valid, evt_ch}), 32'b111);
        do_tick();
        check("ovf_second_expire", 32'(expire), 32'b1000);
        idle(1);
        check("ovf_set", 32'(ovf), 32'b1000);
        check("ovf_evt_stable", 32'({evt_valid, evt_ch}), 32'b111);
        do_cfg(2'd3, 2'b00, 8'd0, 1'b0);
        check("ovf_cleared", 32'(ovf), 32'd0);
        check("ovf_stop_active", 32'(active), 32'd0);
        check("ovf_evt_kept", 32'(evt_valid), 32'd1);
        evt_ready = 1'b1;
        idle(2);
        check("ovf_single_evt", 32'(evt_valid), 32'd0);

        // pointer now 0: ch0 and ch2 -> 0 then 2
        do_cfg(2'd0, 2'b01, 8'd1, 1'b0);
        do_cfg(2'd2, 2'b01, 8'd1, 1'b0);
        do_tick();
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        idle(1);
        check("t3a_first", 32'({evt_valid, evt_ch}), 32'b100);
        idle(1);
        check("t3a_second", 32'({evt_valid, evt_ch}), 32'b110);
        idle(1);

        // command and tick in the same clk: ch1 ignores that tick, ch0 does not
        do_cfg(2'd0, 2'b01, 8'd2, 1'b0);
        do_cfg(2'd1, 2'b01, 8'd5, 1'b1);
        check("cw_active", 32'(active), 32'b0011);
        do_tick();
        exp_q.push_back(2'd0);
        check("cw_t1_expire", 32'(expire), 32'b0001);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check("cw_mid_expire", 32'(expire), 32'd0);
        end
        do_tick();
        exp_q.push_back(2'd1);
        check("cw_t5_expire", 32'(expire), 32'b0010);
        check("cw_active_end", 32'(active), 32'd0);
        idle(3);

        // reset mid-count with an event on display
        evt_ready = 1'b0;
        do_cfg(2'd1, 2'b10, 8'd4, 1'b0);
        do_cfg(2'd2, 2'b01, 8'd1, 1'b0);
        do_tick();
        idle(1);
        check("rr_evt_before", 32'({evt_valid, evt_ch}), 32'b110);
        #1 rst = 1'b1;
        #1;
        check("rr_async_active", 32'(active), 32'd0);
        check("rr_async_evt", 32'(evt_valid), 32'd0);
        check("rr_async_cfg_ready", 32'(cfg_ready), 32'd0);
        idle(2);
        rst = 1'b0;
        check("rr_cfg_ready_low", 32'(cfg_ready), 32'd0);
        idle(1);
        check("rr_cfg_ready_high", 32'(cfg_ready), 32'd1);
        evt_ready = 1'b1;
        do_tick();
        idle(3);
        check("rr_no_events", 32'({evt_valid, active, ovf}), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
